// File: rtl/riscv_pkg.sv
// Shared constants, state encoding and decode helpers for the RV32I multi-cycle sequencer.
package riscv_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_TRAP} state_t;

  typedef struct packed {
    logic       legal;
    logic       is_br;
    logic       src_imm;
    logic [3:0] alu_ctrl;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3, input logic b30);
    dec_t d;
    d = '0;
    case (op)
      OP_R, OP_I: begin
        d.legal   = 1'b1;
        d.src_imm = (op == OP_I);
        case (f3)
          3'b000:  d.alu_ctrl = (op == OP_R && b30) ? ALU_SUB : ALU_ADD;
          3'b001:  d.alu_ctrl = ALU_SLL;
          3'b010:  d.alu_ctrl = ALU_SLT;
          3'b011:  d.alu_ctrl = ALU_SLTU;
          3'b100:  d.alu_ctrl = ALU_XOR;
          3'b101:  d.alu_ctrl = b30 ? ALU_SRA : ALU_SRL;
          3'b110:  d.alu_ctrl = ALU_OR;
          default: d.alu_ctrl = ALU_AND;
        endcase
      end
      OP_B: begin
        d.is_br = 1'b1;
        d.legal = 1'b1;
        case (f3)
          3'b000, 3'b001: d.alu_ctrl = ALU_SUB;
          3'b100, 3'b101: d.alu_ctrl = ALU_SLT;
          3'b110, 3'b111: d.alu_ctrl = ALU_SLTU;
          default:        d.legal    = 1'b0;
        endcase
      end
      default: ;
    endcase
    return d;
  endfunction

  // EQ/NE test the SUB result for zero; the compare forms use the SLT/SLTU bit.
  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] res);
    return f3[2] ? (res[0] ^ f3[0]) : ((res == 32'd0) ^ f3[0]);
  endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational I-type and B-type immediate sign extension.
module riscv_imm_gen (
  input  logic [31:7] i_instr,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_b
);
  assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign o_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/writeback, branch resolution, PC ownership.
// Optional retire counter output enabled by defining RETIRE_CNT_EN.
module riscv_mc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [4:0]  o_rf_ra1,
  output logic [4:0]  o_rf_ra2,
  output logic [4:0]  o_rf_wa,
  output logic        o_rf_we,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_alu_src_imm,
  output logic [31:0] o_imm,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_pc,
  output logic        o_trap
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0] o_retire_cnt
`endif
);
  import riscv_pkg::*;

  state_t      r_state;
  logic [31:0] r_pc, r_instr, r_imm, r_res;
  logic        r_req, r_we, r_src_imm, r_trap, r_br;
  logic [3:0]  r_alu_ctrl;

  logic [31:0] w_imm_i, w_imm_b, w_target;
  logic        w_taken;
  dec_t        w_dec;

  riscv_imm_gen u_imm_gen (
    .i_instr (r_instr[31:7]),
    .o_imm_i (w_imm_i),
    .o_imm_b (w_imm_b)
  );

  assign w_dec    = decode(r_instr[6:0], r_instr[14:12], r_instr[30]);
  assign w_target = r_pc + r_imm;
  assign w_taken  = r_br && br_taken(r_instr[14:12], r_res);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_imm      <= '0;
      r_res      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_src_imm  <= 1'b0;
      r_trap     <= 1'b0;
      r_br       <= 1'b0;
      r_alu_ctrl <= ALU_ADD;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: if (i_imem_ack) begin
          r_instr <= i_imem_rdata;
          r_req   <= 1'b0;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (!w_dec.legal) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end else begin
            r_alu_ctrl <= w_dec.alu_ctrl;
            r_src_imm  <= w_dec.src_imm;
            r_br       <= w_dec.is_br;
            r_imm      <= w_dec.is_br ? w_imm_b : w_imm_i;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= i_alu_result;
          r_we    <= !r_br && (r_instr[11:7] != 5'd0);
          r_state <= S_WB;
        end
        S_WB: begin
          r_we <= 1'b0;
          // A misaligned taken target faults without touching the PC.
          if (w_taken && (w_target[1:0] != 2'b00)) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end else begin
            r_pc    <= w_taken ? w_target : r_pc + 32'd4;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_TRAP: begin
          r_req <= 1'b0;
          r_we  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RETIRE_CNT_EN
  logic [31:0] r_retire;
  always_ff @(posedge i_clk) begin
    if (i_rst)                r_retire <= '0;
    else if (r_state == S_WB) r_retire <= r_retire + 32'd1;
  end
  assign o_retire_cnt = r_retire;
`endif

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_rf_ra1      = r_instr[19:15];
  assign o_rf_ra2      = r_instr[24:20];
  assign o_rf_wa       = r_instr[11:7];
  assign o_rf_we       = r_we;
  assign o_alu_ctrl    = r_alu_ctrl;
  assign o_alu_src_imm = r_src_imm;
  assign o_imm         = r_imm;
  assign o_trap        = r_trap;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: directed vector table, random program vs reference model, trap/reset corners.
module tb_riscv_mc_ctrl;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_imem_ack;
  logic [31:0] i_imem_rdata, i_alu_result;
  logic        o_imem_req, o_rf_we, o_alu_src_imm, o_trap;
  logic [31:0] o_imem_addr, o_imm, o_pc;
  logic [4:0]  o_rf_ra1, o_rf_ra2, o_rf_wa;
  logic [3:0]  o_alu_ctrl;
`ifdef RETIRE_CNT_EN
  logic [31:0] o_retire_cnt;
`endif

  riscv_mc_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_rf_ra1(o_rf_ra1), .o_rf_ra2(o_rf_ra2), .o_rf_wa(o_rf_wa), .o_rf_we(o_rf_we),
    .o_alu_ctrl(o_alu_ctrl), .o_alu_src_imm(o_alu_src_imm), .o_imm(o_imm),
    .i_alu_result(i_alu_result), .o_pc(o_pc), .o_trap(o_trap)
`ifdef RETIRE_CNT_EN
    , .o_retire_cnt(o_retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] pc_m;

  typedef struct {
    logic [31:0] instr;
    int          dly;
    logic [31:0] res;
    logic [3:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic        chk_imm;
    logic        we;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  // External ALU as the datapath would implement it.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: return {31'd0, a < b};
      4'd9: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1; i_start = 1'b0; i_imem_ack = 1'b0; i_imem_rdata = '0; i_alu_result = '0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    pc_m  = 32'h0;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic fetch_ack(input logic [31:0] instr);
    chk("fetch_req", o_imem_req, 1'b1);
    chk("fetch_addr", o_imem_addr, pc_m);
    i_imem_ack = 1'b1; i_imem_rdata = instr;
    @(negedge clk);
    i_imem_ack = 1'b0; i_imem_rdata = $urandom;
  endtask

  // Entered at a FETCH negedge with req up; returns at the next FETCH negedge.
  task automatic run_instr(input logic [31:0] instr, input int dly, input logic use_res, input logic [31:0] res,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] e_alu, input logic e_src,
                           input logic chk_imm, input logic [31:0] e_imm, input logic e_we, input logic [31:0] e_pc);
    logic [31:0] iw;
    iw = instr;
    for (int k = 0; k < dly; k++) begin
      chk("req_hold", o_imem_req, 1'b1);
      chk("addr_hold", o_imem_addr, pc_m);
      i_start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    fetch_ack(instr);
    chk("we_decode", o_rf_we, 1'b0);
    i_start = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("alu_ctrl", o_alu_ctrl, e_alu);
    chk("alu_src_imm", o_alu_src_imm, e_src);
    if (chk_imm) chk("imm", o_imm, e_imm);
    chk("ra1", o_rf_ra1, iw[19:15]);
    chk("ra2", o_rf_ra2, iw[24:20]);
    chk("wa", o_rf_wa, iw[11:7]);
    chk("we_exec", o_rf_we, 1'b0);
    chk("req_exec", o_imem_req, 1'b0);
    i_alu_result = use_res ? res : alu_f(o_alu_ctrl, a, o_alu_src_imm ? o_imm : b);
    i_start = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("we_wb", o_rf_we, e_we);
    i_alu_result = $urandom;
    i_start = 1'($urandom_range(0, 1));
    @(negedge clk);
    i_start = 1'b0;
    chk("we_after", o_rf_we, 1'b0);
    chk("next_req", o_imem_req, 1'b1);
    chk("next_pc", o_pc, e_pc);
    chk("trap_clear", o_trap, 1'b0);
    pc_m = e_pc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] instr, a, b, imm_e, npc;
    logic [11:0] imm12;
    logic [12:0] off;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  e_alu;
    logic        tk;
    int          cls, m;

    tbl[0] = '{enc_i(12'd5, 5'd0, 3'b000, 5'd1),             0, 32'd0, 4'd0, 1'b1, 32'd5,        1'b1, 1'b1, 32'h04};
    tbl[1] = '{enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3),       3, 32'd0, 4'd1, 1'b0, 32'd0,        1'b0, 1'b1, 32'h08};
    tbl[2] = '{enc_i(12'hC00, 5'd6, 3'b000, 5'd5),           1, 32'd0, 4'd0, 1'b1, 32'hFFFFFC00, 1'b1, 1'b1, 32'h0C};
    tbl[3] = '{enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0),       0, 32'd7, 4'd0, 1'b0, 32'd0,        1'b0, 1'b0, 32'h10};
    tbl[4] = '{enc_b(13'd8, 5'd2, 5'd1, 3'b000),             0, 32'd0, 4'd1, 1'b0, 32'd8,        1'b1, 1'b0, 32'h18};
    tbl[5] = '{enc_b(13'd8, 5'd2, 5'd1, 3'b000),             2, 32'd1, 4'd1, 1'b0, 32'd8,        1'b1, 1'b0, 32'h1C};
    tbl[6] = '{enc_b(13'd8, 5'd4, 5'd3, 3'b110),             0, 32'd1, 4'd8, 1'b0, 32'd8,        1'b1, 1'b0, 32'h24};
    tbl[7] = '{enc_b(13'd8, 5'd4, 5'd3, 3'b111),             0, 32'd1, 4'd8, 1'b0, 32'd8,        1'b1, 1'b0, 32'h28};

    // Reset state
    do_reset();
    chk("rst_req", o_imem_req, 1'b0);
    chk("rst_we", o_rf_we, 1'b0);
    chk("rst_src", o_alu_src_imm, 1'b0);
    chk("rst_trap", o_trap, 1'b0);
    chk("rst_alu", o_alu_ctrl, 4'h0);
    chk("rst_imm", o_imm, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_wa", o_rf_wa, 5'd0);
    @(negedge clk);
    chk("idle_no_req", o_imem_req, 1'b0);
    do_start();

    // Directed vector table
    foreach (tbl[i])
      run_instr(tbl[i].instr, tbl[i].dly, 1'b1, tbl[i].res, 32'd0, 32'd0, tbl[i].alu, tbl[i].src,
                tbl[i].chk_imm, tbl[i].imm, tbl[i].we, tbl[i].pc);
`ifdef RETIRE_CNT_EN
    chk("retire_tbl", o_retire_cnt, 32'd8);
`endif

    // Reset while a fetch request is pending: req drops, PC returns, the ack is ignored.
    i_rst = 1'b1; i_imem_ack = 1'b1; i_imem_rdata = enc_i(12'd9, 5'd7, 3'b000, 5'd8);
    @(negedge clk);
    i_rst = 1'b0;
    chk("rstf_req", o_imem_req, 1'b0);
    chk("rstf_pc", o_pc, 32'h0);
    @(negedge clk);
    i_imem_ack = 1'b0;
    chk("rstf_req2", o_imem_req, 1'b0);
    chk("rstf_wa", o_rf_wa, 5'd0);
    pc_m = 32'h0;

    // Random program against the reference model
    do_reset();
    do_start();
    for (int n = 0; n < 300; n++) begin
      cls = $urandom_range(0, 2);
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      if ($urandom_range(0, 7) == 0) rd = 5'd0;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 2) == 0) b = a;
      imm_e = 32'd0;
      if (cls == 0) begin
        m = $urandom_range(0, 9);
        case (m)
          0: begin instr = enc_r(7'h00, rs2, rs1, 3'b000, rd); e_alu = 4'd0; end
          1: begin instr = enc_r(7'h20, rs2, rs1, 3'b000, rd); e_alu = 4'd1; end
          2: begin instr = enc_r(7'h00, rs2, rs1, 3'b111, rd); e_alu = 4'd2; end
          3: begin instr = enc_r(7'h00, rs2, rs1, 3'b110, rd); e_alu = 4'd3; end
          4: begin instr = enc_r(7'h00, rs2, rs1, 3'b100, rd); e_alu = 4'd4; end
          5: begin instr = enc_r(7'h00, rs2, rs1, 3'b001, rd); e_alu = 4'd5; end
          6: begin instr = enc_r(7'h00, rs2, rs1, 3'b101, rd); e_alu = 4'd6; end
          7: begin instr = enc_r(7'h20, rs2, rs1, 3'b101, rd); e_alu = 4'd7; end
          8: begin instr = enc_r(7'h00, rs2, rs1, 3'b011, rd); e_alu = 4'd8; end
          default: begin instr = enc_r(7'h00, rs2, rs1, 3'b010, rd); e_alu = 4'd9; end
        endcase
        npc = pc_m + 32'd4;
        run_instr(instr, $urandom_range(0, 3), 1'b0, 32'd0, a, b, e_alu, 1'b0, 1'b0, 32'd0, rd != 5'd0, npc);
      end else if (cls == 1) begin
        m = $urandom_range(0, 8);
        imm12 = 12'($urandom);
        case (m)
          0: begin instr = enc_i(imm12, rs1, 3'b000, rd); e_alu = 4'd0; end
          1: begin instr = enc_i(imm12, rs1, 3'b100, rd); e_alu = 4'd4; end
          2: begin instr = enc_i(imm12, rs1, 3'b110, rd); e_alu = 4'd3; end
          3: begin instr = enc_i(imm12, rs1, 3'b111, rd); e_alu = 4'd2; end
          4: begin imm12 = {7'h00, imm12[4:0]}; instr = enc_i(imm12, rs1, 3'b001, rd); e_alu = 4'd5; end
          5: begin imm12 = {7'h00, imm12[4:0]}; instr = enc_i(imm12, rs1, 3'b101, rd); e_alu = 4'd6; end
          6: begin imm12 = {7'h20, imm12[4:0]}; instr = enc_i(imm12, rs1, 3'b101, rd); e_alu = 4'd7; end
          7: begin instr = enc_i(imm12, rs1, 3'b010, rd); e_alu = 4'd9; end
          default: begin instr = enc_i(imm12, rs1, 3'b011, rd); e_alu = 4'd8; end
        endcase
        imm_e = {{20{imm12[11]}}, imm12};
        npc = pc_m + 32'd4;
        run_instr(instr, $urandom_range(0, 3), 1'b0, 32'd0, a, b, e_alu, 1'b1, 1'b1, imm_e, rd != 5'd0, npc);
      end else begin
        m = $urandom_range(0, 5);
        off = 13'($urandom_range(0, 2047) * 4);
        imm_e = {{19{off[12]}}, off};
        case (m)
          0: begin instr = enc_b(off, rs2, rs1, 3'b000); e_alu = 4'd1; tk = (a == b); end
          1: begin instr = enc_b(off, rs2, rs1, 3'b001); e_alu = 4'd1; tk = (a != b); end
          2: begin instr = enc_b(off, rs2, rs1, 3'b100); e_alu = 4'd9; tk = ($signed(a) < $signed(b)); end
          3: begin instr = enc_b(off, rs2, rs1, 3'b101); e_alu = 4'd9; tk = ($signed(a) >= $signed(b)); end
          4: begin instr = enc_b(off, rs2, rs1, 3'b110); e_alu = 4'd8; tk = (a < b); end
          default: begin instr = enc_b(off, rs2, rs1, 3'b111); e_alu = 4'd8; tk = (a >= b); end
        endcase
        npc = tk ? pc_m + imm_e : pc_m + 32'd4;
        run_instr(instr, $urandom_range(0, 3), 1'b0, 32'd0, a, b, e_alu, 1'b0, 1'b1, imm_e, 1'b0, npc);
      end
    end
`ifdef RETIRE_CNT_EN
    chk("retire_rand", o_retire_cnt, 32'd300);
`endif

    // Illegal opcode: trap two cycles after ack, sticky until reset.
    do_reset();
    do_start();
    run_instr(enc_i(12'd1, 5'd0, 3'b000, 5'd2), 0, 1'b1, 32'd1, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 32'd1, 1'b1, 32'h4);
    fetch_ack({25'h0AB_CDEF, 7'b0000011});
    chk("ill_trap_early", o_trap, 1'b0);
    @(negedge clk);
    chk("ill_trap", o_trap, 1'b1);
    chk("ill_req", o_imem_req, 1'b0);
    chk("ill_pc", o_pc, 32'h4);
    for (int k = 0; k < 4; k++) begin
      i_start = 1'b1; i_imem_ack = 1'b1;
      @(negedge clk);
      chk("ill_sticky", o_trap, 1'b1);
      chk("ill_req_hold", o_imem_req, 1'b0);
      chk("ill_we", o_rf_we, 1'b0);
      chk("ill_pc_hold", o_pc, 32'h4);
    end
    i_start = 1'b0; i_imem_ack = 1'b0;

    // Branch funct3 010 is illegal.
    do_reset();
    chk("rst_trap_clr", o_trap, 1'b0);
    do_start();
    fetch_ack(enc_b(13'd8, 5'd1, 5'd2, 3'b010));
    @(negedge clk);
    chk("br010_trap", o_trap, 1'b1);
    chk("br010_pc", o_pc, 32'h0);

    // Taken branch to a misaligned target traps with PC unchanged.
    do_reset();
    do_start();
    run_instr(enc_i(12'd3, 5'd0, 3'b000, 5'd2), 0, 1'b1, 32'd3, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 32'd3, 1'b1, 32'h4);
    fetch_ack(enc_b(13'd6, 5'd1, 5'd1, 3'b000));
    @(negedge clk);
    chk("mis_imm", o_imm, 32'd6);
    i_alu_result = 32'd0;
    @(negedge clk);
    chk("mis_we", o_rf_we, 1'b0);
    @(negedge clk);
    chk("mis_trap", o_trap, 1'b1);
    chk("mis_pc", o_pc, 32'h4);
    chk("mis_req", o_imem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
